// File: rtl/addsub_bcd_conv.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) feeding the hex_7seg drivers.
// Optional two's-complement input handling is enabled by defining ADDSUB_SIGNED_INPUT_EN.
module addsub_bcd_conv #(
    parameter int WIDTH = 8
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [3:0]       ONES,
    output logic [3:0]       TENS,
    output logic [3:0]       HUNDREDS,
    output logic             NEG
);

    localparam int SW = WIDTH + 12;
    localparam int CW = $clog2(WIDTH + 1);

    // Handshake: start is sampled only in IDLE; busy is high from the accepting
    // edge until the edge that raises done; done pulses for one cycle with the
    // digits updated on the same edge.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [SW-1:0]   scratch_q;
    logic [SW-1:0]   scratch_adj;
    logic [CW-1:0]   cnt_q;
    logic [WIDTH-1:0] mag;
    logic            accept;

    if (WIDTH < 2 || WIDTH > 9) begin : g_width_check
        $error("addsub_bcd_conv: WIDTH must be in 2..9");
    end

`ifdef ADDSUB_SIGNED_INPUT_EN
    logic bin_neg;
    logic neg_q;

    // Negating the most-negative value wraps to itself, which read as unsigned is its magnitude.
    assign bin_neg = bin[WIDTH-1];
    assign mag     = bin_neg ? (~bin + WIDTH'(1)) : bin;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            neg_q <= 1'b0;
            NEG   <= 1'b0;
        end else begin
            if (accept) begin
                neg_q <= bin_neg;
            end
            if (state == FINISH) begin
                NEG <= neg_q;
            end
        end
    end
`else
    assign mag = bin;
    assign NEG = 1'b0;
`endif

    assign accept = (state == IDLE) && start;
    assign busy   = (state != IDLE);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == CW'(1)) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Add-3 on every BCD nibble >= 5 before the shift; nibbles never carry for legal WIDTH.
    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < 3; i++) begin
            if (scratch_q[WIDTH + 4*i +: 4] >= 4'd5) begin
                scratch_adj[WIDTH + 4*i +: 4] = scratch_q[WIDTH + 4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            scratch_q <= '0;
            cnt_q     <= '0;
            done      <= 1'b0;
            ONES      <= 4'd0;
            TENS      <= 4'd0;
            HUNDREDS  <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        scratch_q <= {12'd0, mag};
                        cnt_q     <= CW'(WIDTH);
                    end
                end
                SHIFT: begin
                    scratch_q <= {scratch_adj[SW-2:0], 1'b0};
                    cnt_q     <= cnt_q - CW'(1);
                end
                FINISH: begin
                    ONES     <= scratch_q[WIDTH +: 4];
                    TENS     <= scratch_q[WIDTH + 4 +: 4];
                    HUNDREDS <= scratch_q[WIDTH + 8 +: 4];
                    done     <= 1'b1;
                end
                default: begin
                    scratch_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_bcd_conv.sv
// Self-checking bench for addsub_bcd_conv (WIDTH=8): table-driven conversions plus handshake corner cases.
module tb_addsub_bcd_conv;

    localparam int WIDTH = 8;

    logic             CLOCK_50;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] bin;
    logic             busy;
    logic             done;
    logic [3:0]       ONES;
    logic [3:0]       TENS;
    logic [3:0]       HUNDREDS;
    logic             NEG;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] b;
        logic       neg;
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
    } vec_t;

    vec_t vecs[12];

    addsub_bcd_conv #(.WIDTH(WIDTH)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .ONES     (ONES),
        .TENS     (TENS),
        .HUNDREDS (HUNDREDS),
        .NEG      (NEG)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int digits();
        return {19'd0, NEG, HUNDREDS, TENS, ONES};
    endfunction

    // One full conversion; prev is the result that must be held while busy.
    task automatic do_conv(input vec_t v, input int prev);
        int k;
        start = 1'b1;
        bin   = v.b;
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        bin   = 8'($urandom_range(0, 255));
        chk("busy_after_accept", busy, 1);
        for (k = 1; k <= 20; k++) begin
            @(posedge CLOCK_50); #1;
            if (k == 5) chk("held_mid_conv", digits(), prev);
            if (done) break;
        end
        chk("latency", k, WIDTH + 1);
        chk("busy_in_done_cycle", busy, 0);
        chk("result", digits(), {19'd0, v.neg, v.h, v.t, v.o});
        @(posedge CLOCK_50); #1;
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        int prev;
        int k;
        int extra_done;
`ifdef ADDSUB_SIGNED_INPUT_EN
        vecs[0]  = '{8'hF9, 1'b1, 4'd0, 4'd0, 4'd7};
        vecs[1]  = '{8'h80, 1'b1, 4'd1, 4'd2, 4'd8};
        vecs[2]  = '{8'h7F, 1'b0, 4'd1, 4'd2, 4'd7};
        vecs[3]  = '{8'h00, 1'b0, 4'd0, 4'd0, 4'd0};
        vecs[4]  = '{8'h64, 1'b0, 4'd1, 4'd0, 4'd0};
        vecs[5]  = '{8'hFF, 1'b1, 4'd0, 4'd0, 4'd1};
        vecs[6]  = '{8'h9C, 1'b1, 4'd1, 4'd0, 4'd0};
        vecs[7]  = '{8'hC8, 1'b1, 4'd0, 4'd5, 4'd6};
        vecs[8]  = '{8'h09, 1'b0, 4'd0, 4'd0, 4'd9};
        vecs[9]  = '{8'h0A, 1'b0, 4'd0, 4'd1, 4'd0};
        vecs[10] = '{8'h63, 1'b0, 4'd0, 4'd9, 4'd9};
        vecs[11] = '{8'h2A, 1'b0, 4'd0, 4'd4, 4'd2};
`else
        vecs[0]  = '{8'd0,   1'b0, 4'd0, 4'd0, 4'd0};
        vecs[1]  = '{8'd255, 1'b0, 4'd2, 4'd5, 4'd5};
        vecs[2]  = '{8'd99,  1'b0, 4'd0, 4'd9, 4'd9};
        vecs[3]  = '{8'd100, 1'b0, 4'd1, 4'd0, 4'd0};
        vecs[4]  = '{8'd1,   1'b0, 4'd0, 4'd0, 4'd1};
        vecs[5]  = '{8'd9,   1'b0, 4'd0, 4'd0, 4'd9};
        vecs[6]  = '{8'd10,  1'b0, 4'd0, 4'd1, 4'd0};
        vecs[7]  = '{8'd199, 1'b0, 4'd1, 4'd9, 4'd9};
        vecs[8]  = '{8'd7,   1'b0, 4'd0, 4'd0, 4'd7};
        vecs[9]  = '{8'd200, 1'b0, 4'd2, 4'd0, 4'd0};
        vecs[10] = '{8'd128, 1'b0, 4'd1, 4'd2, 4'd8};
        vecs[11] = '{8'd42,  1'b0, 4'd0, 4'd4, 4'd2};
`endif

        // Clock/reset
        reset = 1'b1;
        start = 1'b1;
        bin   = 8'd55;
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_digits", digits(), 0);
        start = 1'b0;
        reset = 1'b0;
        @(posedge CLOCK_50); #1;
        chk("idle_busy", busy, 0);

        // Table-driven conversions
        prev = 0;
        for (int i = 0; i < 12; i++) begin
            do_conv(vecs[i], prev);
            prev = {19'd0, vecs[i].neg, vecs[i].h, vecs[i].t, vecs[i].o};
        end

        // Start while busy is ignored and not queued; bin change after capture has no effect
        start = 1'b1;
        bin   = 8'd100;
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #1;
        start = 1'b1;
        bin   = 8'd7;
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        chk("ign_busy", busy, 1);
        for (k = 4; k <= 20; k++) begin
            @(posedge CLOCK_50); #1;
            if (done) break;
        end
        chk("ign_latency", k, WIDTH + 1);
        chk("ign_result", digits(), {19'd0, 1'b0, 4'd1, 4'd0, 4'd0});
        extra_done = 0;
        for (int j = 0; j < 12; j++) begin
            @(posedge CLOCK_50); #1;
            if (done || busy) extra_done++;
        end
        chk("ign_not_queued", extra_done, 0);

        // Reset mid-SHIFT aborts
        start = 1'b1;
        bin   = 8'd200;
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        reset = 1'b1;
        @(posedge CLOCK_50); #1;
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_digits", digits(), 0);
        extra_done = 0;
        for (int j = 0; j < 12; j++) begin
            @(posedge CLOCK_50); #1;
            if (done) extra_done++;
        end
        chk("abort_no_done", extra_done, 0);

        // Start held high: back-to-back every WIDTH+2 edges
        start = 1'b1;
        bin   = 8'd42;
        @(posedge CLOCK_50); #1;
        bin = 8'd137;
        for (k = 1; k <= 29; k++) begin
            @(posedge CLOCK_50); #1;
            if (k % 10 == 0) bin = ((k / 10) % 2 == 0) ? 8'd137 : 8'd42;
            chk("held_done", done, (k % 10 == 9) ? 1 : 0);
            if (k % 10 == 9) begin
                chk("held_busy", busy, 0);
                if ((k / 10) == 1) begin
`ifdef ADDSUB_SIGNED_INPUT_EN
                    chk("held_result", digits(), {19'd0, 1'b1, 4'd1, 4'd1, 4'd9});
`else
                    chk("held_result", digits(), {19'd0, 1'b0, 4'd1, 4'd3, 4'd7});
`endif
                end else begin
                    chk("held_result", digits(), {19'd0, 1'b0, 4'd0, 4'd4, 4'd2});
                end
            end
        end
        start = 1'b0;
        repeat (2) @(posedge CLOCK_50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
